write_image: RTL and testbench

WRITE_IMAGE -- requirements
Module: write_image

---
 rtl/write_image_pkg.sv | 21 ++
 rtl/write_image_frame_ram.sv | 52 +++++
 rtl/write_image.sv | 119 +++++++++++
 tb/tb_write_image.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/write_image_pkg.sv
// Shared frame geometry defaults and capture state encoding for the image
// writer and the pixel-reader block.
package image_pkg;

    localparam int IMG_WIDTH  = 668;
    localparam int IMG_HEIGHT = 452;
    localparam int IMG_PIX_W  = 8;
    localparam int IMG_ADDR_W = 19;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } img_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/write_image_frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port
// with read-before-write behaviour and zero data for out-of-range reads.
module frame_ram
    import image_pkg::*;
#(
    parameter int DEPTH  = IMG_WIDTH * IMG_HEIGHT,
    parameter int PIX_W  = IMG_PIX_W,
    parameter int ADDR_W = IMG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [PIX_W-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [PIX_W-1:0]  rd_data_o
);

    // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] rd_data_q;
    logic [PIX_W-1:0] rd_data_d;
    logic             rd_in_range;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_in_range = ({1'b0, rd_addr_i} < DEPTH_L);
        rd_data_d   = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = rd_in_range ? mem[rd_addr_i] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/write_image.sv
// Captures one raster-order frame of pixels into frame_ram on request and
// offers registered readback of the stored image at any time.
module write_image
    import image_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT,
    parameter int PIX_W  = IMG_PIX_W,
    parameter int ADDR_W = IMG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [PIX_W-1:0]  in_data,
    output logic              in_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              busy,
    output logic              line_done,
    output logic              frame_done
);

    localparam int X_W = cnt_w(WIDTH);
    localparam int Y_W = cnt_w(HEIGHT);
    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    img_state_t        state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              line_done_q, line_done_d;
    logic              accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            line_done_q <= line_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        x_d         = x_q;
        y_d         = y_q;
        line_done_d = 1'b0;
        in_ready    = 1'b0;
        busy        = 1'b0;
        frame_done  = 1'b0;
        accept      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CAPTURE;
                    wr_addr_d = '0;
                    x_d       = '0;
                    y_d       = '0;
                end
            end
            CAPTURE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (x_q == X_LAST) begin
                        x_d         = '0;
                        line_done_d = 1'b1;
                        if (y_q == Y_LAST) begin
                            state_d = DONE;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign line_done = line_done_q;

    frame_ram #(
        .DEPTH (WIDTH * HEIGHT),
        .PIX_W (PIX_W),
        .ADDR_W(ADDR_W)
    ) u_frame_ram (
        .clk      (clk),
        .rst      (rst),
        .we_i     (accept),
        .wr_addr_i(wr_addr_q),
        .wr_data_i(in_data),
        .rd_en_i  (rd_en),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data)
    );

endmodule

// File: tb/tb_write_image.sv
// Directed and randomized bench for write_image on a 4x3 frame, checked
// against a linear-address memory image kept by the bench.
module tb_write_image;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       line_done;
    logic       frame_done;

    int tests  = 0;
    int failed = 0;

    logic [7:0] mem_model [N];
    logic [7:0] pix [N];

    write_image #(
        .WIDTH (W),
        .HEIGHT(H),
        .PIX_W (8),
        .ADDR_W(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .line_done (line_done),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] exp;
        for (int a = 0; a < 16; a++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(a);
            tick();
            exp = (a < N) ? mem_model[a] : 8'h00;
            chk($sformatf("readback[%0d]", a), rd_data, exp);
        end
        rd_en = 1'b0;
    endtask

    // Capture pix[] as one frame; optional random idle gaps, a read of
    // address 5 in the cycle pixel 5 is written, and a stray start pulse.
    task automatic run_frame(input bit gaps, input bit rd5, input int start_after);
        logic [7:0] old5;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready", in_ready, 1);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                for (int g = 0; g < 6 && $urandom_range(0, 1) == 1; g++) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    tick();
                    chk("gap_busy", busy, 1);
                    chk("gap_line_done", line_done, 0);
                end
            end
            in_valid = 1'b1;
            in_data  = pix[i];
            old5     = mem_model[5];
            if (rd5 && i == 5) begin
                rd_en   = 1'b1;
                rd_addr = 4'd5;
            end
            tick();
            if (rd5 && i == 5) begin
                chk("read_before_write", rd_data, old5);
                rd_en = 1'b0;
            end
            mem_model[i] = pix[i];
            chk($sformatf("line_done@%0d", i), line_done, (i % W) == W - 1);
            chk($sformatf("frame_done@%0d", i), frame_done, i == N - 1);
            chk($sformatf("busy@%0d", i), busy, i != N - 1);
            if (i == start_after) begin
                in_valid = 1'b0;
                start    = 1'b1;
                tick();
                start = 1'b0;
                chk("restart_ignored_busy", busy, 1);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("post_frame_done", frame_done, 0);
        chk("post_busy", busy, 0);
        chk("post_ready", in_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] old1;
        logic [7:0] hold;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_line_done", line_done, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_rd_data", rd_data, 0);
        tick();
        tick();
        #2;
        rst = 1'b0;
        tick();

        // Back-to-back pixels 0x00..0x0B.
        for (int i = 0; i < N; i++) pix[i] = 8'(i);
        run_frame(1'b0, 1'b0, -1);
        check_all();

        // Random gaps, pixels 0xA0..0xAB.
        for (int i = 0; i < N; i++) pix[i] = 8'(8'hA0 + i);
        run_frame(1'b1, 1'b0, -1);
        check_all();

        // Valid pixels offered in IDLE must be ignored.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_ready", in_ready, 0);
            chk("idle_busy", busy, 0);
        end
        in_valid = 1'b0;
        check_all();

        // Start pulse mid-capture must not restart the frame.
        for (int i = 0; i < N; i++) pix[i] = 8'(8'h30 + i);
        run_frame(1'b0, 1'b0, 5);
        check_all();

        // Reset after pixel 6 aborts; memory keeps what was written.
        old1  = mem_model[1];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h60 + i);
            rd_en    = (i == 0);
            rd_addr  = 4'd1;
            tick();
            rd_en        = 1'b0;
            mem_model[i] = 8'(8'h60 + i);
        end
        in_valid = 1'b0;
        chk("pre_rst_rd_data", rd_data, old1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ready", in_ready, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_line_done", line_done, 0);
        chk("async_rst_frame_done", frame_done, 0);
        chk("async_rst_rd_data", rd_data, 0);
        tick();
        #2;
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        tick();
        chk("post_rst_ready", in_ready, 0);
        chk("post_rst_busy", busy, 0);
        in_valid = 1'b0;
        check_all();
        for (int i = 0; i < N; i++) pix[i] = 8'(8'h10 + i);
        run_frame(1'b0, 1'b0, -1);
        check_all();

        // Read-before-write at address 5, then repeat read, out-of-range, hold.
        for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
        pix[5] = 8'h22;
        run_frame(1'b1, 1'b0, -1);
        for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
        pix[5] = 8'h55;
        run_frame(1'b0, 1'b1, -1);
        rd_en   = 1'b1;
        rd_addr = 4'd5;
        tick();
        chk("reread_5", rd_data, 8'h55);
        rd_addr = 4'd13;
        tick();
        chk("oob_13", rd_data, 8'h00);
        rd_addr = 4'd2;
        tick();
        hold = mem_model[2];
        chk("read_2", rd_data, hold);
        rd_en   = 1'b0;
        rd_addr = 4'd7;
        tick();
        chk("rd_hold", rd_data, hold);

        // Fully random frames with gaps.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
            run_frame(1'b1, 1'b0, -1);
            check_all();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
